// File: rtl/div_unit.sv
// div_unit: multi-cycle iterative integer divider for DIV, DIVU, REM and REMU.
// Restoring shift-subtract, one quotient bit per clock. Sits beside the ALU.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           request, sampled only in IDLE or DONE
//   op              00=DIV 01=DIVU 10=REM 11=REMU, captured with start
//   A, B            dividend / divisor, captured with start
//   busy            high while iterating
//   done            one-cycle pulse, Result valid
//   Result          quotient or remainder, held until the next result
//   Z, N            Result == 0, Result sign bit
//   DivZero         captured divisor was zero, held with Result
//
// state  | meaning
// S_IDLE | waiting for start
// S_BUSY | iterating; count == WIDTH means the final sign-fix edge is next
// S_DONE | Result valid, done high; start accepted here as from IDLE
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Z,
  output logic             N,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q;
  logic             busy_q, done_q, divzero_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] dvd_q;   // dividend shifts out the top, quotient bits shift in
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic             qneg_q, rneg_q, sel_rem_q;

  // Operand capture and special-case decode
  logic             signed_op, a_neg, b_neg, b_zero, ovf;
  logic [WIDTH-1:0] a_mag, b_mag, special_res;

  always_comb begin
    signed_op   = ~op[0];
    a_neg       = signed_op & A[WIDTH-1];
    b_neg       = signed_op & B[WIDTH-1];
    a_mag       = a_neg ? ('0 - A) : A;
    b_mag       = b_neg ? ('0 - B) : B;
    b_zero      = (B == '0);
    ovf         = signed_op & (A == MIN_NEG) & (B == '1);
    special_res = '0;
    if (b_zero) special_res = op[1] ? A : '1;
    else        special_res = op[1] ? '0 : A;
  end

  // One restoring step; the shifted remainder is WIDTH+1 bits so a set top
  // bit still compares correctly against divisors above 2^(WIDTH-1).
  logic [WIDTH:0]   rem_sh;
  logic             fits;
  logic [WIDTH-1:0] rem_d, dvd_d, q_fix, r_fix, res_fix;

  always_comb begin
    rem_sh  = {rem_q, dvd_q[WIDTH-1]};
    fits    = (rem_sh >= {1'b0, dvs_q});
    rem_d   = fits ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
    dvd_d   = {dvd_q[WIDTH-2:0], fits};
    q_fix   = qneg_q ? ('0 - dvd_q) : dvd_q;
    r_fix   = rneg_q ? ('0 - rem_q) : rem_q;
    res_fix = sel_rem_q ? r_fix : q_fix;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      result_q  <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      sel_rem_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            dvd_q     <= a_mag;
            dvs_q     <= b_mag;
            rem_q     <= '0;
            cnt_q     <= '0;
            qneg_q    <= a_neg ^ b_neg;
            rneg_q    <= a_neg;
            sel_rem_q <= op[1];
            if (b_zero || ovf) begin
              result_q  <= special_res;
              divzero_q <= b_zero;
              state_q   <= S_DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              state_q <= S_BUSY;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        S_BUSY: begin
          if (cnt_q == CW'(WIDTH)) begin
            result_q  <= res_fix;
            divzero_q <= 1'b0;
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign Result  = result_q;
  assign DivZero = divzero_q;
  assign Z       = (result_q == '0);
  assign N       = result_q[WIDTH-1];

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit with directed vectors.
module tb_div_unit;

  localparam int W = 32;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, Z, N, DivZero;
  logic [W-1:0] Result;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .Result(Result), .Z(Z), .N(N), .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         dz;
    int           at_edge;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int busy_total = 0;
  int pushed = 0;

  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Caller is at a negedge; start is sampled at the following posedge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic dz, input logic special);
    exp_t e;
    start = 1'b1; op = o; A = a; B = b;
    e.res = res;
    e.dz = dz;
    e.at_edge = edge_cnt + 1 + (special ? 0 : W + 1);
    sb.push_back(e);
    pushed++;
    @(negedge clk);
    start = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] res, input logic dz, input logic special);
    issue(o, a, b, res, dz, special);
    drain();
    @(negedge clk);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got done=0 expected 1");
    end
  endtask

  initial begin
    int b0, d0;
    fork
      forever begin
        @(negedge clk);
        if (busy) busy_total++;
        if (done) begin
          exp_t e;
          done_seen++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 result %h expected no done", Result);
          end else begin
            e = sb.pop_front();
            chk("result", Result, e.res);
            chk("Z", {31'b0, Z}, {31'b0, (e.res == '0)});
            chk("N", {31'b0, N}, {31'b0, e.res[W-1]});
            chk("DivZero", {31'b0, DivZero}, {31'b0, e.dz});
            chk("latency_edge", edge_cnt, e.at_edge);
          end
        end
      end
    join_none

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_result", Result, 0);
    chk("rst_Z", {31'b0, Z}, 1);
    chk("rst_N", {31'b0, N}, 0);
    chk("rst_dz", {31'b0, DivZero}, 0);
    rst = 1'b0;
    @(negedge clk);

    b0 = busy_total;
    run(OP_DIVU, 100, 7, 14, 0, 0);
    chk("busy_len_ok", {31'b0, ((busy_total - b0) >= W) && ((busy_total - b0) <= W + 1)}, 1);
    run(OP_REMU, 100, 7, 2, 0, 0);
    run(OP_DIV, -7, 2, 32'hFFFF_FFFD, 0, 0);
    run(OP_REM, -7, 2, 32'hFFFF_FFFF, 0, 0);
    run(OP_DIV, 7, -2, 32'hFFFF_FFFD, 0, 0);
    run(OP_REM, 7, -2, 1, 0, 0);
    run(OP_DIV, -8, -2, 4, 0, 0);
    run(OP_REM, -8, 3, 32'hFFFF_FFFE, 0, 0);
    run(OP_DIVU, 0, 5, 0, 0, 0);
    run(OP_DIV, 5, 0, 32'hFFFF_FFFF, 1, 1);
    run(OP_REM, 5, 0, 5, 1, 1);
    run(OP_REMU, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1, 1);
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1);
    run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1);
    run(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    run(OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
    run(OP_DIVU, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 0);
    run(OP_REMU, 32'hFFFF_FFFF, 32'hC000_0001, 32'h3FFF_FFFE, 0, 0);
    run(OP_DIVU, 32'hFFFF_FFFF, 32'hC000_0000, 1, 0, 0);
    run(OP_REMU, 32'hFFFF_FFFF, 32'hC000_0000, 32'h3FFF_FFFF, 0, 0);

    // start while busy must be ignored
    issue(OP_DIVU, 100, 7, 14, 0, 0);
    repeat (10) @(negedge clk);
    start = 1'b1; op = OP_DIVU; A = 1; B = 1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (40) @(negedge clk);
    chk("one_done_per_op", done_seen, pushed);

    // start accepted in the DONE cycle, chained through a special case
    issue(OP_DIVU, 100, 7, 14, 0, 0);
    wait_done();
    issue(OP_REMU, 100, 7, 2, 0, 0);
    wait_done();
    issue(OP_DIV, 5, 0, 32'hFFFF_FFFF, 1, 1);
    drain();
    repeat (5) @(negedge clk);
    chk("chain_dones", done_seen, pushed);

    // asynchronous reset mid-operation
    issue(OP_DIVU, 100, 7, 14, 0, 0);
    repeat (10) @(negedge clk);
    d0 = done_seen;
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_result", Result, 0);
    chk("midrst_Z", {31'b0, Z}, 1);
    sb.delete();
    pushed--;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_no_done", done_seen, d0);
    run(OP_DIVU, 9, 3, 3, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
